// File: rtl/mmio_sig_collector.sv
//-----------------------------------------------------------------------------
// mmio_sig_collector
//
// Capture stage that sits directly behind the tiny-SoC MMIO master port.
// It decodes writes into the signature window and turns dump and stream
// writes into records tagged with a per-kind running index. Each record
// is buffered in a small FIFO together with its taint shadow. The block
// also follows the stop drain window and the SIMLEN cycle limit, and
// raises one sticky done flag that a testbench can wait on.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   mmio_req_i       MMIO request
//   mmio_we_i        MMIO write enable
//   mmio_addr_i      MMIO byte address (exact compare against the window)
//   mmio_wdata_i     MMIO write data
//   mmio_wdata_i_t0  taint shadow of the write data
//   simlen_i         cycle limit, 0 disables it
//   rec_valid_o      FIFO head is valid
//   rec_ready_i      consumer pops the head when valid
//   rec_kind_o       0 = int reg dump, 1 = float reg dump, 2 = reg stream
//   rec_idx_o        per-kind index of the head record
//   rec_data_o       captured data of the head record
//   rec_taint_o      captured taint of the head record
//   stop_seen_o      sticky, a stop write has been seen
//   trap_cnt_o       count of trap writes, saturating
//   drop_cnt_o       count of records lost to a full FIFO, saturating
//   done_o           sticky end-of-run flag
//-----------------------------------------------------------------------------
module mmio_sig_collector #(
    parameter int          DEPTH      = 8,
    parameter int          IDX_W      = 8,
    parameter int          STOP_DRAIN = 50,
    parameter logic [31:0] SIG_BASE   = 32'h6000_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mmio_req_i,
    input  logic              mmio_we_i,
    input  logic [31:0]       mmio_addr_i,
    input  logic [63:0]       mmio_wdata_i,
    input  logic [63:0]       mmio_wdata_i_t0,
    input  logic [31:0]       simlen_i,
    output logic              rec_valid_o,
    input  logic              rec_ready_i,
    output logic [1:0]        rec_kind_o,
    output logic [IDX_W-1:0]  rec_idx_o,
    output logic [63:0]       rec_data_o,
    output logic [63:0]       rec_taint_o,
    output logic              stop_seen_o,
    output logic [15:0]       trap_cnt_o,
    output logic [15:0]       drop_cnt_o,
    output logic              done_o
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int DRAIN_W = $clog2(STOP_DRAIN + 1);

    localparam logic [1:0] KIND_INT   = 2'd0;
    localparam logic [1:0] KIND_FLOAT = 2'd1;
    localparam logic [1:0] KIND_STRM  = 2'd2;

    typedef struct packed {
        logic [1:0]       kind;
        logic [IDX_W-1:0] idx;
        logic [63:0]      data;
        logic [63:0]      taint;
    } rec_t;

    rec_t               mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic [IDX_W-1:0]   idx_int;
    logic [IDX_W-1:0]   idx_float;
    logic [IDX_W-1:0]   idx_strm;

    logic [DRAIN_W-1:0] drain_cnt;
    logic [31:0]        cyc_cnt;

    logic               wr_access;
    logic               hit_stop;
    logic               hit_trap;
    logic               hit_reg;
    logic               hit_freg;
    logic               hit_strm;
    logic               gated;
    logic               rec_hit;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic               done_set;
    rec_t               new_rec;
    rec_t               head;

    assign wr_access = mmio_req_i & mmio_we_i;
    assign hit_stop  = wr_access & (mmio_addr_i == SIG_BASE);
    assign hit_trap  = wr_access & (mmio_addr_i == SIG_BASE + 32'h08);
    assign hit_reg   = wr_access & (mmio_addr_i == SIG_BASE + 32'h10);
    assign hit_freg  = wr_access & (mmio_addr_i == SIG_BASE + 32'h18);
    assign hit_strm  = wr_access & (mmio_addr_i == SIG_BASE + 32'h20);

    // Once stop is seen or the run is done, only the FIFO keeps moving.
    assign gated   = stop_seen_o | done_o;
    assign rec_hit = (hit_reg | hit_freg | hit_strm) & ~gated;

    // The record carries the index value before this write bumps it.
    always_comb begin
        new_rec       = '0;
        new_rec.data  = mmio_wdata_i;
        new_rec.taint = mmio_wdata_i_t0;
        if (hit_reg) begin
            new_rec.kind = KIND_INT;
            new_rec.idx  = idx_int;
        end else if (hit_freg) begin
            new_rec.kind = KIND_FLOAT;
            new_rec.idx  = idx_float;
        end else begin
            new_rec.kind = KIND_STRM;
            new_rec.idx  = idx_strm;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign full = (count == CNT_W'(DEPTH));
    assign pop  = rec_valid_o & rec_ready_i;
    assign push = rec_hit & (~full | pop);
    assign drop = rec_hit & full & ~pop;

    // Drain reaching 1 means this is the last cycle of the stop window.
    assign done_set = (stop_seen_o & (drain_cnt == DRAIN_W'(1))) |
                      ((simlen_i != 32'd0) & (cyc_cnt == simlen_i - 32'd1));

    assign head        = mem[rd_ptr];
    assign rec_valid_o = (count != '0);
    assign rec_kind_o  = rec_valid_o ? head.kind  : '0;
    assign rec_idx_o   = rec_valid_o ? head.idx   : '0;
    assign rec_data_o  = rec_valid_o ? head.data  : '0;
    assign rec_taint_o = rec_valid_o ? head.taint : '0;

    // Storage needs no reset; the outputs are masked by rec_valid_o.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            idx_int     <= IDX_W'(1);
            idx_float   <= '0;
            idx_strm    <= '0;
            drain_cnt   <= '0;
            cyc_cnt     <= '0;
            stop_seen_o <= 1'b0;
            trap_cnt_o  <= '0;
            drop_cnt_o  <= '0;
            done_o      <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Indices advance on drops too so lost records show as gaps.
            if (rec_hit) begin
                if (hit_reg) begin
                    idx_int <= idx_int + IDX_W'(1);
                end else if (hit_freg) begin
                    idx_float <= idx_float + IDX_W'(1);
                end else begin
                    idx_strm <= idx_strm + IDX_W'(1);
                end
            end

            if (drop && drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            if (hit_trap && !gated && trap_cnt_o != 16'hFFFF) begin
                trap_cnt_o <= trap_cnt_o + 16'd1;
            end

            if (hit_stop && !gated) begin
                stop_seen_o <= 1'b1;
                drain_cnt   <= DRAIN_W'(STOP_DRAIN);
            end else if (!done_o && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end

            if (!done_o) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (done_set) begin
                done_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mmio_sig_collector.md
Name: mmio_sig_collector

Overview:
- Synthesizable capture stage directly downstream of the tiny-SoC MMIO master port; consumes the MMIO signature traffic that the taint testbench otherwise decodes by polling.
- Decodes signature writes (stop, trap, int-reg dump, float-reg dump, reg stream), tags each with a per-kind running index, and buffers the value and its taint shadow in a FIFO.
- Tracks the stop drain window and the SIMLEN limit, and raises a single done flag the bench can wait on.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- IDX_W, 8, width of per-kind index counters; wraps modulo 2^IDX_W.
- STOP_DRAIN, 50, cycles between the stop-signature write and done.
- SIG_BASE, 32'h6000_0000, base of the signature window.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- mmio_req_i  in  1  MMIO request.
- mmio_we_i  in  1  write enable.
- mmio_addr_i  in  32  byte address.
- mmio_wdata_i  in  64  write data.
- mmio_wdata_i_t0  in  64  taint shadow of the write data.
- simlen_i  in  32  cycle limit; 0 disables the limit.
- rec_valid_o  out  1  FIFO head valid.
- rec_ready_i  in  1  consumer pops the head.
- rec_kind_o  out  2  0=int reg dump, 1=float reg dump, 2=reg stream.
- rec_idx_o  out  IDX_W  per-kind index of the record.
- rec_data_o  out  64  captured data.
- rec_taint_o  out  64  captured taint.
- stop_seen_o  out  1  sticky; a stop write was seen.
- trap_cnt_o  out  16  trap-signature writes seen; saturates at 16'hFFFF.
- drop_cnt_o  out  16  records dropped because the FIFO was full; saturates.
- done_o  out  1  sticky end-of-run.

Behaviour:
- Address decode, exact 32-bit compare:
  - STOP = SIG_BASE+0x00
  - TRAP = +0x08
  - REG_DUMP = +0x10
  - FREG_DUMP = +0x18
  - REG_STREAM = +0x20
- A signature write is mmio_req_i & mmio_we_i & decode hit. Reads and non-matching addresses are ignored.
- Gating: after stop_seen_o or done_o, dump, stream and trap writes are ignored. Their counters do not change.
- Index counters:
  - Reset values: int = 1, float = 0, stream = 0.
  - A counter increments by 1 on every accepted write of its kind, whether the record is pushed or dropped, so drops show up as index gaps.
  - The record carries the pre-increment value.
  - Counters wrap 2^IDX_W−1 → 0.
- FIFO:
  - Each record is {kind, idx, data, taint}.
  - Push latency: a write in cycle N gives rec_valid_o in cycle N+1 when the FIFO was empty. There is no combinational input-to-output path.
  - A pop occurs when rec_valid_o & rec_ready_i.
  - Full with a simultaneous pop: the push is accepted.
  - Full with no pop: the record is dropped and drop_cnt_o increments.
  - Output fields are stable while rec_valid_o=1 and rec_ready_i=0.
  - Pointers wrap modulo DEPTH. A separate count register disambiguates full from empty.
- Stop handling:
  - The first STOP write in cycle N sets stop_seen_o at N+1.
  - It loads the drain counter with STOP_DRAIN.
  - The drain counter decrements once per cycle and sets done_o in cycle N+STOP_DRAIN+1.
  - Later STOP writes are ignored.
- Cycle counter:
  - Starts at 0 in the first cycle after reset deasserts and increments every cycle until done_o.
  - If simlen_i≠0 and cyc == simlen_i−1 in cycle M, done_o is 1 at M+1.
  - If SIMLEN and the drain both expire, done_o asserts on whichever comes first.
- After done_o:
  - No pushes; the FIFO still drains.
  - The cycle counter and drain counter freeze.
- Reset (asynchronous, any time, including mid-drain):
  - All outputs go to 0: rec_valid_o, rec_kind_o, rec_idx_o, rec_data_o, rec_taint_o, stop_seen_o, trap_cnt_o, drop_cnt_o, done_o.
  - FIFO empties; index counters return to their reset values; drain and cycle counters clear.
- Taint is carried bit-exact. Resolving X taint to 0 is the bench's job, not this block's.

Test Plan:
- Dumps: REG_DUMP writes 0xA, 0xB with taint 0x0 and 0xF0, rec_ready_i=1 → two records, kind=0, idx 1 then 2, data 0xA/0xB, taint 0x0/0xF0; each valid one cycle after its write.
- Interleaved kinds: STREAM, FREG_DUMP, STREAM → records (2,0), (1,0), (2,1) in that order.
- Overflow: rec_ready_i=0, 10 REG_DUMP writes with DEPTH=8 → 8 records idx 1..8 retained, drop_cnt_o=2. Releasing ready then yields idx 1..8; the next write gets idx 11.
- Full push with pop: FIFO full, rec_ready_i=1, new write in the same cycle → accepted, drop_cnt_o unchanged.
- Stop: STOP written at cycle 100, REG_DUMP at cycle 110 → stop_seen_o=1 at 101, no record for the dump, done_o rises at 151. A TRAP write at 105 leaves trap_cnt_o=0.
- SIMLEN / reset: simlen_i=20, no stop → done_o rises at cycle 20 after reset release. Asserting rst_ni=0 mid-drain clears done_o, stop_seen_o and the FIFO immediately, and the int index restarts at 1.
